// File: rtl/cf_i2s_tx.sv
// -----------------------------------------------------------------------------
// cf_i2s_tx -- I2S master transmitter
//
// Generates sck/ws from clk through a programmable prescaler and shifts
// right-aligned samples, pulled from a valid/ready stream, MSB-first on sdo.
// Sits between the TX sample FIFO and the DAC/codec pins.
//
// Parameters
//   PW              prescaler width (bits of sck_prescaler)
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   en              run enable; 0 freezes prescaler, sck, ws, bit counter, shifter
//   sck_prescaler   sck half-period = sck_prescaler+1 clk cycles
//   left_justified  1: left-justified, 0: standard I2S (1-sck data delay)
//   sample_size     valid bits per sample 1..32 (0 or >32 means 32)
//   channels        {left_en, right_en}
//   in_data/in_valid/in_ready  sample stream (right-aligned words)
//   underrun_clr    clears the sticky underrun flag
//   sck, ws, sdo    I2S pins; sdo changes on sck falling edges
//   underrun        sticky: an enabled slot started without a sample
//
// Optional feature
//   I2S_TX_MONO_DUP_EN  when defined, with a single channel enabled the word
//                       loaded for the enabled slot is repeated in the
//                       following disabled slot. Undefined: disabled slots
//                       carry zeros.
// -----------------------------------------------------------------------------
module cf_i2s_tx #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [PW-1:0] sck_prescaler,
    input  logic          left_justified,
    input  logic [5:0]    sample_size,
    input  logic [1:0]    channels,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          underrun_clr,
    output logic          sck,
    output logic          ws,
    output logic          sdo,
    output logic          underrun
);

    // One-entry skid between the stream and the shifter.
    typedef struct packed {
        logic        full;
        logic [31:0] data;
    } hold_t;

    hold_t         hold;
    logic [PW-1:0] prescaler;
    logic [4:0]    bit_ctr;
    logic [31:0]   shifter;

    logic          tick;         // prescaler expiry: sck toggles
    logic          fe;           // sck falling edge
    logic          slot_start;   // first falling edge of a 32-bit slot
    logic          slot_is_left; // slot beginning at this fe belongs to left
    logic          slot_chan_en; // that slot's channel is enabled
    logic [5:0]    eff_size;
    logic [4:0]    align_sh;
    logic [31:0]   hold_aligned;
    logic [31:0]   load_val;
    logic [31:0]   shifter_nxt;

`ifdef I2S_TX_MONO_DUP_EN
    logic [31:0]   dup_data;     // last word loaded into an enabled slot
    logic          mono;
`endif

    // ------------------------------------------------------------------
    // Edge / slot decode
    // ------------------------------------------------------------------
    assign tick       = en & (prescaler == '0);
    assign fe         = tick & sck;
    assign slot_start = fe & (bit_ctr == 5'd0);

    // ws toggles at slot start, so the new slot's ws is ~ws. I2S: left is
    // ws=0 (old ws=1); LJ: left is ws=1 (old ws=0).
    assign slot_is_left = left_justified ? ~ws : ws;
    assign slot_chan_en = slot_is_left ? channels[1] : channels[0];

    assign eff_size     = ((sample_size == 6'd0) || (sample_size > 6'd32)) ? 6'd32 : sample_size;
    assign align_sh     = 5'(6'd32 - eff_size);
    // Bits above sample_size shift out; LSBs are zero-filled.
    assign hold_aligned = hold.data << align_sh;

`ifdef I2S_TX_MONO_DUP_EN
    assign mono = channels[1] ^ channels[0];
`endif

    always_comb begin
        load_val = '0;
        if (slot_chan_en) begin
            load_val = hold.full ? hold_aligned : 32'd0;
        end else begin
`ifdef I2S_TX_MONO_DUP_EN
            load_val = mono ? dup_data : 32'd0;
`else
            load_val = 32'd0;
`endif
        end
    end

    // Slot start replaces the shift with a fresh load, so shifter[31] holds
    // the new MSB right after the ws edge.
    assign shifter_nxt = slot_start ? load_val : {shifter[30:0], 1'b0};

    // ------------------------------------------------------------------
    // Timing chain: prescaler, sck, ws, bit counter, shifter, sdo
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            sck       <= 1'b0;
            ws        <= 1'b1;
            bit_ctr   <= 5'd0;
            shifter   <= '0;
            sdo       <= 1'b0;
        end else if (tick) begin
            prescaler <= sck_prescaler;
            sck       <= ~sck;
            if (fe) begin
                bit_ctr <= bit_ctr + 5'd1;
                shifter <= shifter_nxt;
                // LJ drives the bit just loaded/shifted in; I2S drives the
                // previous one, which delays the stream by one sck.
                sdo     <= left_justified ? shifter_nxt[31] : shifter[31];
                if (slot_start)
                    ws <= ~ws;
            end
        end else if (en) begin
            prescaler <= prescaler - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hold register: consumed by an enabled slot start, refilled from the
    // stream whenever empty (independent of en).
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else begin
            if (slot_start && slot_chan_en && hold.full)
                hold.full <= 1'b0;
            // Empty hold: accept, even on an underrunning slot start; the
            // word then waits for the next enabled slot.
            if (in_valid && !hold.full) begin
                hold.full <= 1'b1;
                hold.data <= in_data;
            end
        end
    end

    assign in_ready = ~hold.full;

    // ------------------------------------------------------------------
    // Sticky underrun; a set in the same cycle beats the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            underrun <= 1'b0;
        else if (slot_start && slot_chan_en && !hold.full)
            underrun <= 1'b1;
        else if (underrun_clr)
            underrun <= 1'b0;
    end

`ifdef I2S_TX_MONO_DUP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dup_data <= '0;
        else if (slot_start && slot_chan_en)
            dup_data <= load_val;
    end
`endif

endmodule

// File: tb/tb_cf_i2s_tx.sv
module tb_cf_i2s_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  psc;
    logic        lj;
    logic [5:0]  ssz;
    logic [1:0]  ch;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        underrun_clr;
    logic        sck, ws, sdo, underrun;

    cf_i2s_tx #(.PW(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sck_prescaler(psc),
        .left_justified(lj), .sample_size(ssz), .channels(ch),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .underrun_clr(underrun_clr), .sck(sck), .ws(ws), .sdo(sdo),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            if (errs <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: expected (ws, sdo) per sck falling edge
    bit          exp_sdo[$];
    bit          exp_ws[$];
    logic [31:0] feed[$];    // words waiting to be offered on the stream
    logic [31:0] words[$];   // words for the next case
    int          hs_cnt = 0;
    bit          mon_on = 0;
    int          cur_p  = 0;

    // stream driver: offers feed[0] until accepted
    bit drv_pend = 0;
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            if (drv_pend) begin
                void'(feed.pop_front());
                hs_cnt++;
                drv_pend = 0;
            end
            if (feed.size() > 0) begin
                in_valid = 1'b1;
                in_data  = feed[0];
                drv_pend = in_ready;
            end else begin
                in_valid = 1'b0;
                drv_pend = 0;
            end
        end
    end

    // monitor: detects sck falling edges and checks against the queues
    bit mon_sck_prev = 0;
    bit mon_first    = 0;
    int mon_en_cnt   = 0;
    bit mon_en_s;
    initial begin
        forever begin
            @(posedge clk);
            mon_en_s = en;
            #1;
            if (!mon_on) begin
                mon_first  = 0;
                mon_en_cnt = 0;
            end else begin
                if (mon_en_s) mon_en_cnt++;
                if (mon_sck_prev && !sck) begin
                    if (mon_first) chk("sck_period", mon_en_cnt, 2 * (cur_p + 1));
                    mon_first  = 1;
                    mon_en_cnt = 0;
                    if (exp_sdo.size() > 0) begin
                        chk("ws", ws, exp_ws.pop_front());
                        chk("sdo", sdo, exp_sdo.pop_front());
                    end
                end
            end
            mon_sck_prev = sck;
        end
    end

    task automatic wait_feed_empty();
        int n = 0;
        while (feed.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (feed.size() > 0) chk("feed_drain_timeout", feed.size(), 0);
    endtask

    task automatic reset_dut();
        wait_feed_empty();
        @(negedge clk);
        mon_on = 0;
        rst_n = 1'b0; en = 1'b0; underrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sck", sck, 0);
        chk("rst_ws", ws, 1);
        chk("rst_sdo", sdo, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_underrun", underrun, 0);
        rst_n = 1'b1;
    endtask

    function automatic bit slot_enabled(bit l, bit [1:0] c, int s);
        bit left = l ? (s % 2 == 1) : (s % 2 == 0);
        return left ? c[1] : c[0];
    endfunction

    // One case: reset, configure, model the bitstream for nslots slots from
    // `words`, stream them and let the monitor compare.
    task automatic run_case(input int p, input bit l, input int sz, input bit [1:0] c,
                            input int nslots, input bit freeze);
        int  esz, wi, exp_hs, hs0, bound, cyc, fz_at;
        bit  exp_uf, prev;
        bit  sb[32];
        bit  dup[32];
        logic [31:0] w;
        bit  fz_sck, fz_ws, fz_sdo;

        reset_dut();
        psc = 8'(p); lj = l; ssz = 6'(sz); ch = c; cur_p = p;

        esz = (sz == 0 || sz > 32) ? 32 : sz;
        wi = 0; prev = 0; exp_uf = 0;
        for (int k = 0; k < 32; k++) dup[k] = 0;
        for (int s = 0; s < nslots; s++) begin
            if (slot_enabled(l, c, s)) begin
                if (wi < words.size()) begin
                    w = words[wi];
                    wi++;
                    for (int k = 0; k < 32; k++) sb[k] = (k < esz) ? w[esz-1-k] : 1'b0;
                end else begin
                    for (int k = 0; k < 32; k++) sb[k] = 0;
                    exp_uf = 1;
                end
                dup = sb;
            end else begin
`ifdef I2S_TX_MONO_DUP_EN
                if (c == 2'b01 || c == 2'b10) sb = dup;
                else for (int k = 0; k < 32; k++) sb[k] = 0;
`else
                for (int k = 0; k < 32; k++) sb[k] = 0;
`endif
            end
            for (int k = 0; k < 32; k++) begin
                exp_ws.push_back(bit'(s % 2));
                exp_sdo.push_back(l ? sb[k] : prev);
                prev = sb[k];
            end
        end
        exp_hs = (wi < words.size()) ? wi + 1 : wi;

        hs0 = hs_cnt;
        foreach (words[i]) feed.push_back(words[i]);
        repeat (3) @(negedge clk);
        mon_on = 1;
        en = 1'b1;

        bound = nslots * 32 * 2 * (p + 1) * 2 + 100;
        fz_at = freeze ? int'($urandom_range(10, 100)) : -100;
        cyc = 0;
        while (exp_sdo.size() > 0 && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (cyc == fz_at) begin
                en = 1'b0;
                fz_sck = sck; fz_ws = ws; fz_sdo = sdo;
            end
            if (cyc == fz_at + 10) begin
                chk("freeze_sck", sck, fz_sck);
                chk("freeze_ws", ws, fz_ws);
                chk("freeze_sdo", sdo, fz_sdo);
                en = 1'b1;
            end
        end
        if (exp_sdo.size() > 0) chk("bitstream_timeout", exp_sdo.size(), 0);
        chk("underrun", underrun, exp_uf);
        chk("handshakes", hs_cnt - hs0, exp_hs);
        en = 1'b0;
        mon_on = 0;
        exp_sdo.delete();
        exp_ws.delete();
        words.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, sz, ns, nen, nw, n;
        bit l, ws0;
        bit [1:0] c;

        rst_n = 1'b0; en = 1'b0; psc = '0; lj = 1'b0; ssz = 6'd16; ch = 2'b11;
        underrun_clr = 1'b0;

        // standard I2S and LJ with two known words
        words.push_back(32'h0000A5C3); words.push_back(32'h00001234);
        run_case(1, 0, 16, 2'b11, 2, 0);
        words.push_back(32'h0000A5C3); words.push_back(32'h00001234);
        run_case(1, 1, 16, 2'b11, 2, 0);

        // left-only, one word per frame
        words.push_back(32'h0000FFFF); words.push_back(32'h0000FFFF);
        run_case(1, 0, 16, 2'b10, 4, 0);

        // fastest and slower sck with an en gap
        words.push_back(32'hDEADBEEF); words.push_back(32'h12345678);
        run_case(0, 0, 24, 2'b11, 2, 1);
        words.push_back(32'hCAFEF00D); words.push_back(32'h0F0F0F0F);
        run_case(3, 1, 32, 2'b11, 2, 1);

        // no data: underrun, clear, re-set at next slot
        run_case(1, 0, 16, 2'b11, 2, 0);
        @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("underrun_clr", underrun, 0);
        ws0 = ws;
        en = 1'b1;
        n = 0;
        while (ws == ws0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("ws_toggle_seen", (ws != ws0), 1);
        chk("underrun_reset", underrun, 1);

        // reset mid-slot with the hold register full
        en = 1'b0;
        feed.push_back(32'h00005555);
        wait_feed_empty();
        @(negedge clk);
        chk("hold_full", in_ready, 0);
        en = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sck", sck, 0);
        chk("async_rst_ws", ws, 1);
        chk("async_rst_sdo", sdo, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_underrun", underrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0;

        // randomized cases
        for (int t = 0; t < 10; t++) begin
            p  = $urandom_range(0, 3);
            l  = 1'($urandom_range(0, 1));
            sz = $urandom_range(0, 40);
            c  = 2'($urandom_range(0, 3));
            ns = $urandom_range(2, 6);
            nen = 0;
            for (int s = 0; s < ns; s++) if (slot_enabled(l, c, s)) nen++;
            nw = $urandom_range(0, nen + 1);
            for (int i = 0; i < nw; i++) words.push_back($urandom);
            run_case(p, l, sz, c, ns, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
